// File: rtl/seq_pattern_detector_if.sv
// rtl/seq_pattern_detector_if.sv - serial bit / pattern / status bundle for the pattern detector
interface seq_pattern_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             i;
  logic             en;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             clear;
  logic             o;
  logic [CNT_W-1:0] match_count;

  // Stimulus side: drives the bitstream and control, observes the match outputs.
  modport master (
    output i, en, overlap, pat_load, pat_in, clear,
    input  o, match_count
  );

  // Detector side.
  modport slave (
    input  i, en, overlap, pat_load, pat_in, clear,
    output o, match_count
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - runtime-loadable serial pattern detector with saturating match count
module seq_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1101)
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_pattern_detector_if.slave bus
);

  // fill must be able to hold the value PAT_W itself, hence PAT_W+1 states.
  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  r_hist;
  logic [PAT_W-1:0]  r_pat;
  logic [FILL_W-1:0] r_fill;
  logic              r_o;
  logic [CNT_W-1:0]  r_count;

  logic [PAT_W-1:0]  w_hist_nxt;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic              w_o_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  logic [PAT_W-1:0]  w_hist_sh;
  logic [FILL_W-1:0] w_fill_inc;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_match;

  // Candidate history/fill if the current bit is accepted; the fill gate keeps a
  // cleared (all-zero) history from matching an all-zero pattern too early.
  assign w_hist_sh   = {r_hist[PAT_W-2:0], bus.i};
  assign w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
  assign w_match     = (w_fill_inc == FILL_FULL) && (w_hist_sh == r_pat);
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);

  // Next-state selection in priority order: load, clear, enabled bit, idle.
  always_comb begin
    w_hist_nxt  = r_hist;
    w_pat_nxt   = r_pat;
    w_fill_nxt  = r_fill;
    w_o_nxt     = 1'b0;
    w_count_nxt = r_count;
    if (bus.pat_load) begin
      w_pat_nxt  = bus.pat_in;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (bus.clear) begin
      w_count_nxt = '0;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else if (bus.en) begin
      w_o_nxt = w_match;
      if (w_match) begin
        w_count_nxt = w_count_inc;
      end
      if (w_match && !bus.overlap) begin
        w_hist_nxt = '0;
        w_fill_nxt = '0;
      end else begin
        w_hist_nxt = w_hist_sh;
        w_fill_nxt = w_fill_inc;
      end
    end
  end

  // State registers; reset is asynchronous so o and the count drop immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_pat   <= RST_PAT;
      r_fill  <= '0;
      r_o     <= 1'b0;
      r_count <= '0;
    end else begin
      r_hist  <= w_hist_nxt;
      r_pat   <= w_pat_nxt;
      r_fill  <= w_fill_nxt;
      r_o     <= w_o_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.o           = r_o;
  assign bus.match_count = r_count;

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

- Parametrised successor to the fixed "1101" Moore sequence detector.
- Serial bitstream detector with a PAT_W-bit pattern that is loadable at runtime.
- Detection mode is selectable: overlapping or non-overlapping.
- Has a per-bit enable and a saturating match counter.
- Sits on the serial input path; `o` feeds downstream control logic and `match_count` is read by status logic.

## Interface
Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16.
- CNT_W, 8: width of `match_count`.
- RST_PAT, 4'b1101 (zero-extended/truncated to PAT_W): pattern value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high. Clears all state immediately.
- i  in  1  serial data bit, sampled on a rising edge when `en`=1.
- en  in  1  bit qualifier; when 0, `i` is ignored and history is held.
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- pat_load  in  1  load `pat_in` as the new pattern.
- pat_in  in  PAT_W  new pattern. MSB is compared against the oldest bit (first received).
- clear  in  1  synchronous clear of `match_count` and history.
- o  out  PAT_W-independent, 1  registered (Moore) match flag.
- match_count  out  CNT_W  number of matches since reset/clear; saturating.

## Operation
- State:
  - `hist[PAT_W-1:0]` shift register; newest bit goes in at the LSB.
  - `fill` counter, 0..PAT_W, saturating at PAT_W.
  - `pat` register.
  - `o` register.
  - `match_count` register.
- Reset values: hist=0, fill=0, pat=RST_PAT, o=0, match_count=0.
- Per rising edge, highest priority first:
  1. `pat_load`=1: pat←pat_in, hist←0, fill←0, o←0. `i`, `clear` and `en` are ignored this cycle; the count is held.
  2. `clear`=1: match_count←0, hist←0, fill←0, o←0.
  3. `en`=1:
     - hist_n = {hist[PAT_W-2:0], i}; fill_n = min(fill+1, PAT_W).
     - match = (fill_n==PAT_W) && (hist_n==pat).
     - o←match; match_count←match_count+1 on match, saturating at 2^CNT_W−1.
     - On match with overlap=1: hist←hist_n, fill←fill_n.
     - On match with overlap=0: hist←0, fill←0.
     - On no match: hist←hist_n, fill←fill_n.
  4. `en`=0: hist, fill and match_count hold; o←0.
- No match is possible until PAT_W bits have been received since the last reset/clear/load. This applies to an all-zero pattern as well.
- `overlap` is sampled with each bit; a change affects only matches completed by that bit onward.
- `o` is a pure register output; no combinational path from `i` to `o`.

## Timing
- Latency: a bit that completes the pattern is sampled at edge k; `o`=1 is visible after edge k, for the cycle k→k+1.
- `match_count` updates at the same edge k.
- `o` stays high on consecutive cycles only if each successive sampled bit completes a new match. This requires overlap=1 and a self-overlapping pattern, e.g. 1111 with a run of 1s.
- Bench convention: drive `i`/`en` at the falling edge and check 1 ns after the rising edge.
- Asserting `rst` mid-stream clears `o` and the count without waiting for a clock edge. After `rst` deasserts, PAT_W fresh bits are needed before the next match.
- `pat_load` takes effect at its edge. The first bit evaluated against the new pattern is the one sampled at the next enabled edge.

## Test plan
- **Overlap, default pattern:** pattern 1101, overlap=1, en=1, stream 1101101101 → `o` high after bits 4, 7 and 10; match_count=3.
- **Non-overlap:** same stream with overlap=0 → `o` high after bits 4 and 10 only; match_count=2.
- **Runtime load:** pat_load with pat_in=0110, then stream 0110110 with overlap=1 → pulses after bits 4 and 7. Loading a pattern mid-stream after bits 011 → no match until 4 new bits have arrived.
- **Reset and clear mid-stream:**
  - Bits 110, assert rst for 1 ns, then bit 1 → no pulse; `o`=0 and match_count=0 immediately on rst.
  - `clear` asserted in the same cycle as a completing bit → no pulse; count=0.
- **Saturation and continuous o:** CNT_W=2, pattern 1111, overlap=1, ten 1s → `o` high from bit 4 through bit 10 continuously; match_count sequence 1, 2, 3, 3, ….
- **Enable gating:** bits 1,1 with en=1, then 3 cycles with en=0 while `i` toggles, then bits 0,1 with en=1 → single pulse after the final bit. `o`=0 during the en=0 cycles.
